// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32 decode register with a one-entry hold buffer and load-use bubble.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] InstIn,
    input  logic [31:0] PCIn,
    input  logic        InstValid,
    output logic        InstReady,
    input  logic        Stall,
    input  logic        Flush,
    output logic [6:0]  Opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [19:0] immA,
    output logic [11:0] immB,
    output logic [6:0]  immC,
    output logic [4:0]  immD,
    output logic [31:0] PCOut,
    output logic        Valid,
    output logic        LoadUse
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;

    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic        r_hold_full;

    logic        w_cand_valid;
    logic [31:0] w_cand_inst;
    logic [6:0]  w_cand_op;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_load_use;

    // The hold buffer always outranks the live input as the next candidate.
    assign w_cand_valid = r_hold_full | InstValid;
    assign w_cand_inst  = r_hold_full ? r_hold_inst : InstIn;
    assign w_cand_op    = w_cand_inst[6:0];

    assign w_uses_rs1 = (w_cand_op != c_OP_LUI) && (w_cand_op != c_OP_AUIPC) &&
                        (w_cand_op != c_OP_JAL);
    assign w_uses_rs2 = (w_cand_op == c_OP_RTYPE) || (w_cand_op == c_OP_STORE) ||
                        (w_cand_op == c_OP_BRANCH);

    assign w_load_use = r_valid && (r_ir[6:0] == c_OP_LOAD) && (r_ir[11:7] != 5'd0) &&
                        w_cand_valid &&
                        ((w_uses_rs1 && (w_cand_inst[19:15] == r_ir[11:7])) ||
                         (w_uses_rs2 && (w_cand_inst[24:20] == r_ir[11:7])));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ir        <= NOP_INST;
            r_pc        <= RESET_PC;
            r_valid     <= 1'b0;
            r_hold_full <= 1'b0;
        end else if (Flush) begin
            r_ir        <= NOP_INST;
            r_valid     <= 1'b0;
            r_hold_full <= 1'b0;
        end else if (Stall) begin
            if (InstValid && !r_hold_full) begin
                r_hold_inst <= InstIn;
                r_hold_pc   <= PCIn;
                r_hold_full <= 1'b1;
            end
        end else if (w_load_use) begin
            r_ir    <= NOP_INST;
            r_valid <= 1'b0;
            if (!r_hold_full) begin
                r_hold_inst <= InstIn;
                r_hold_pc   <= PCIn;
                r_hold_full <= 1'b1;
            end
        end else if (r_hold_full) begin
            r_ir        <= r_hold_inst;
            r_pc        <= r_hold_pc;
            r_valid     <= 1'b1;
            r_hold_full <= 1'b0;
        end else if (InstValid) begin
            r_ir    <= InstIn;
            r_pc    <= PCIn;
            r_valid <= 1'b1;
        end else begin
            r_ir    <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign InstReady = !r_hold_full;
    assign LoadUse   = w_load_use;
    assign Opcode    = r_ir[6:0];
    assign funct3    = r_ir[14:12];
    assign funct7    = r_ir[31:25];
    assign rd        = r_ir[11:7];
    assign rs1       = r_ir[19:15];
    assign rs2       = r_ir[24:20];
    assign immA      = r_ir[31:12];
    assign immB      = r_ir[31:20];
    assign immC      = r_ir[31:25];
    assign immD      = r_ir[11:7];
    assign PCOut     = r_pc;
    assign Valid     = r_valid;

endmodule
`default_nettype wire
